// File: rtl/ts_null_inserter.sv
// Turns a gapped, show-ahead FIFO stream into a continuous 188-byte TS stream.
// A packet is passed only when it is fully buffered; otherwise a null packet is sent.
module ts_null_inserter #(
  parameter int          PKT_LEN  = 188,
  parameter logic [12:0] NULL_PID = 13'h1FFF,
  parameter int          USEDW_W  = 9
) (
  input  logic               clk_27,
  input  logic               RST,
  input  logic               EN,
  input  logic [7:0]         FIFO_Q,
  input  logic               FIFO_EMPTY,
  input  logic [USEDW_W-1:0] FIFO_USEDW,
  output logic               FIFO_RDREQ,
  output logic [7:0]         DATA_OUT,
  output logic               D_VALID_OUT,
  output logic               P_SYNC_OUT,
  output logic               SYNC_LOST,
  output logic [31:0]        NULL_CNT,
  output logic [15:0]        DROP_CNT,
  output logic [15:0]        UNDERRUN_CNT
);

  localparam int         BC_W       = $clog2(PKT_LEN);
  localparam logic [7:0] SYNC_BYTE  = 8'h47;
  localparam logic [7:0] STUFF_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_NULL = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [BC_W-1:0] bc;
  logic [3:0]      cc;
  logic            underran;
  logic            last_byte, boundary, pass_ok;
  logic [7:0]      byte_p0;
  logic            vld_p0, sync_p0, hunt, ur_hit;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] null_byte(input logic [BC_W-1:0] pos, input logic [3:0] cnt);
    case (pos)
      BC_W'(0): return SYNC_BYTE;
      BC_W'(1): return {3'b000, NULL_PID[12:8]};
      BC_W'(2): return NULL_PID[7:0];
      BC_W'(3): return {4'h1, cnt};
      default:  return STUFF_BYTE;
    endcase
  endfunction

  assign last_byte = (bc == BC_W'(PKT_LEN - 1));
  assign boundary  = (state == S_IDLE) || last_byte;
  // Only a sync byte at the head with a whole packet behind it is worth passing.
  assign pass_ok   = !FIFO_EMPTY && (FIFO_Q == SYNC_BYTE) &&
                     (32'(FIFO_USEDW) >= 32'(PKT_LEN));

  always_ff @(posedge clk_27 or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (boundary) begin
      if (!EN)          state_nxt = S_IDLE;
      else if (pass_ok) state_nxt = S_PASS;
      else              state_nxt = S_NULL;
    end
  end

  always_comb begin
    FIFO_RDREQ = 1'b0;
    byte_p0    = 8'h00;
    vld_p0     = 1'b0;
    sync_p0    = 1'b0;
    hunt       = 1'b0;
    ur_hit     = 1'b0;
    case (state)
      S_PASS: begin
        vld_p0  = 1'b1;
        sync_p0 = (bc == '0);
        // Once the FIFO runs dry the rest of the packet is stuffed, even if data reappears.
        if (FIFO_EMPTY || underran) begin
          byte_p0 = STUFF_BYTE;
          ur_hit  = !underran;
        end else begin
          FIFO_RDREQ = 1'b1;
          byte_p0    = FIFO_Q;
        end
      end
      S_NULL: begin
        vld_p0     = 1'b1;
        sync_p0    = (bc == '0);
        byte_p0    = null_byte(bc, cc);
        hunt       = !FIFO_EMPTY && (FIFO_Q != SYNC_BYTE);
        FIFO_RDREQ = hunt;
      end
      default: ;
    endcase
  end

  // Stage p0 -> registered outputs and status counters
  always_ff @(posedge clk_27 or negedge RST) begin
    if (!RST) begin
      bc           <= '0;
      cc           <= 4'h0;
      underran     <= 1'b0;
      DATA_OUT     <= 8'h00;
      D_VALID_OUT  <= 1'b0;
      P_SYNC_OUT   <= 1'b0;
      SYNC_LOST    <= 1'b0;
      NULL_CNT     <= 32'd0;
      DROP_CNT     <= 16'd0;
      UNDERRUN_CNT <= 16'd0;
    end else begin
      bc          <= boundary ? '0 : bc + BC_W'(1);
      DATA_OUT    <= byte_p0;
      D_VALID_OUT <= vld_p0;
      P_SYNC_OUT  <= sync_p0;
      if (boundary)    underran <= 1'b0;
      else if (ur_hit) underran <= 1'b1;
      if (state == S_NULL && last_byte) cc <= cc + 4'h1;
      if (state == S_NULL && bc == '0)  NULL_CNT <= sat_inc32(NULL_CNT);
      if (hunt)   DROP_CNT     <= sat_inc16(DROP_CNT);
      if (ur_hit) UNDERRUN_CNT <= sat_inc16(UNDERRUN_CNT);
      if (state == S_PASS && bc == '0) SYNC_LOST <= 1'b0;
      else if (hunt)                   SYNC_LOST <= 1'b1;
    end
  end

endmodule
